rv32_imm_gen: RTL and testbench



---
 rtl/rv32_imm_gen.sv | 51 +++++
 tb/tb_rv32_imm_gen.sv | 137 +++++++++++++
 2 files changed

// File: rtl/rv32_imm_gen.sv
// RV32I immediate generator: routes instr[31:7] into the I/S/B/U/J immediate.
// Combinational result plus a registered copy for the execute stage.
module rv32_imm_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [24:0] inst,
  input  logic [2:0]  imm_sel,
  output logic [31:0] out,
  output logic        sel_err,
  output logic [31:0] out_q,
  output logic        sel_err_q
);

  localparam logic [2:0] I_TYPE = 3'd0;
  localparam logic [2:0] S_TYPE = 3'd1;
  localparam logic [2:0] B_TYPE = 3'd2;
  localparam logic [2:0] U_TYPE = 3'd3;
  localparam logic [2:0] J_TYPE = 3'd4;

  logic sgn;
  assign sgn = inst[24];

  always_comb begin
    out     = 32'h0;
    sel_err = 1'b0;
    unique case (imm_sel)
      I_TYPE: out = {{20{sgn}}, inst[24:13]};
      S_TYPE: out = {{20{sgn}}, inst[24:18], inst[4:0]};
      B_TYPE: out = {{19{sgn}}, sgn, inst[0],
                     inst[23:18], inst[4:1], 1'b0};
      U_TYPE: out = {inst[24:5], 12'h0};
      J_TYPE: out = {{11{sgn}}, sgn, inst[12:5],
                     inst[13], inst[23:14], 1'b0};
      default: begin
        out     = 32'h0;
        sel_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= 32'h0;
      sel_err_q <= 1'b0;
    end else begin
      out_q     <= out;
      sel_err_q <= sel_err;
    end
  end

endmodule

// File: tb/tb_rv32_imm_gen.sv
// Directed bench for rv32_imm_gen: format vectors, reserved select,
// registered path and asynchronous reset behaviour.
module tb_rv32_imm_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [24:0] inst;
  logic [2:0]  imm_sel;
  logic [31:0] out;
  logic        sel_err;
  logic [31:0] out_q;
  logic        sel_err_q;

  int checks = 0;
  int errors = 0;

  rv32_imm_gen dut (
    .clk(clk),
    .rst_n(rst_n),
    .inst(inst),
    .imm_sel(imm_sel),
    .out(out),
    .sel_err(sel_err),
    .out_q(out_q),
    .sel_err_q(sel_err_q)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag,
                      input logic got,
                      input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic apply(input logic [31:0] instr,
                       input logic [2:0] sel);
    inst    = instr[31:7];
    imm_sel = sel;
  endtask

  task automatic vec(input string tag,
                     input logic [31:0] instr,
                     input logic [2:0] sel,
                     input logic [31:0] exp);
    apply(instr, sel);
    #1;
    chk32(tag, out, exp);
    chk1({tag, "_err"}, sel_err, 1'b0);
  endtask

  initial begin
    rst_n   = 1'b0;
    inst    = '0;
    imm_sel = 3'd0;
    #1;
    chk32("rst_out_q", out_q, 32'h0);
    chk1("rst_err_q", sel_err_q, 1'b0);

    vec("I_pos", 32'h00C48413, 3'd0, 32'd12);
    vec("I_neg", 32'hFFC48413, 3'd0, 32'hFFFFFFFC);
    vec("S_pos", 32'h00941823, 3'd1, 32'd16);
    vec("S_neg", 32'hFE941E23, 3'd1, 32'hFFFFFFFC);
    vec("B_pos", 32'h00A48E63, 3'd2, 32'd28);
    vec("B_neg", 32'hFEA48863, 3'd2, 32'hFFFFF7F0);
    vec("U",     32'h54321437, 3'd3, 32'h54321000);
    vec("J_pos", 32'h7FFFF0EF, 3'd4, 32'h000FFFFE);
    vec("J_neg", 32'h800000EF, 3'd4, 32'hFFF00000);

    apply(32'hFFFFFFFF, 3'd7);
    #1;
    chk32("rsv7_out", out, 32'h0);
    chk1("rsv7_err", sel_err, 1'b1);
    apply(32'hFFFFFFFF, 3'd5);
    #1;
    chk32("rsv5_out", out, 32'h0);
    chk1("rsv5_err", sel_err, 1'b1);

    @(posedge clk);
    #1;
    chk32("held_out_q", out_q, 32'h0);
    chk1("held_err_q", sel_err_q, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk32("rsv_out_q", out_q, 32'h0);
    chk1("rsv_err_q", sel_err_q, 1'b1);

    @(negedge clk);
    apply(32'h00C48413, 3'd0);
    #1;
    chk32("pre_edge_q", out_q, 32'h0);
    @(posedge clk);
    #1;
    chk32("I_out_q", out_q, 32'd12);
    chk1("I_err_q", sel_err_q, 1'b0);

    @(negedge clk);
    apply(32'h800000EF, 3'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk32("mid_rst_q", out_q, 32'h0);
    chk32("mid_rst_out", out, 32'hFFF00000);
    @(posedge clk);
    #1;
    chk32("rst_hold_q", out_q, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk32("J_out_q", out_q, 32'hFFF00000);
    chk1("J_err_q", sel_err_q, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
